// File: rtl/tour_cmd_sequencer.sv
// Command sequencer between the UART wrapper, the tour move store and cmd_proc.
// Idle: transparent mux for UART commands. During a tour: replays each stored
// knight move as a vertical command followed by a horizontal (fanfare) command.
//
//   state  | meaning
//   IDLE   | UART commands pass straight through to cmd_proc
//   VERT   | vertical command for move[mv_indx] offered to cmd_proc
//   WAIT_V | vertical command consumed, waiting for its completion
//   HORZ   | horizontal command for move[mv_indx] offered to cmd_proc
//   WAIT_H | horizontal command consumed, waiting for its completion
module tour_cmd_sequencer #(
  parameter int         NUM_MOVES = 24,
  parameter logic [7:0] RESP_MID  = 8'h5A,
  parameter logic [7:0] RESP_DONE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_active,
  output logic        err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] WAIT_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] WAIT_H = 3'd4;

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  logic [2:0]  state, nxt_state;
  logic [1:0]  dx_mag, dy_mag;
  logic        dx_neg, dy_neg;
  logic        move_ok;
  logic        last_move;
  logic [15:0] vert_cmd, horz_cmd;

  // Decode the one-hot move word into per-axis magnitude and direction
  always_comb begin
    dx_mag = 2'd0;
    dy_mag = 2'd0;
    dx_neg = 1'b0;
    dy_neg = 1'b0;
    case (move)
      8'h01: begin dx_mag = 2'd1;                 dy_mag = 2'd2;                 end
      8'h02: begin dx_mag = 2'd1; dx_neg = 1'b1; dy_mag = 2'd2;                 end
      8'h04: begin dx_mag = 2'd2; dx_neg = 1'b1; dy_mag = 2'd1;                 end
      8'h08: begin dx_mag = 2'd2; dx_neg = 1'b1; dy_mag = 2'd1; dy_neg = 1'b1; end
      8'h10: begin dx_mag = 2'd1; dx_neg = 1'b1; dy_mag = 2'd2; dy_neg = 1'b1; end
      8'h20: begin dx_mag = 2'd1;                 dy_mag = 2'd2; dy_neg = 1'b1; end
      8'h40: begin dx_mag = 2'd2;                 dy_mag = 2'd1; dy_neg = 1'b1; end
      8'h80: begin dx_mag = 2'd2;                 dy_mag = 2'd1;                 end
      default: begin end
    endcase
  end

  assign move_ok   = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign last_move = (mv_indx == LAST_IDX);
  assign vert_cmd  = {4'h4, (dy_neg ? 8'h7F : 8'h00), 2'b00, dy_mag};
  assign horz_cmd  = {4'h5, (dx_neg ? 8'h3F : 8'hBF), 2'b00, dx_mag};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Move index: cleared at tour start, advanced after each completed move, never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mv_indx <= 5'd0;
    else if (state == IDLE && start_tour)
      mv_indx <= 5'd0;
    else if (state == WAIT_H && send_resp && !last_move)
      mv_indx <= mv_indx + 5'd1;
  end

  // Next-state logic; only the handshake belonging to the current state is honoured
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (start_tour) nxt_state = VERT;
      VERT:    if (!move_ok) nxt_state = IDLE;
               else if (clr_cmd_rdy) nxt_state = WAIT_V;
      WAIT_V:  if (send_resp) nxt_state = HORZ;
      HORZ:    if (clr_cmd_rdy) nxt_state = WAIT_H;
      WAIT_H:  if (send_resp) nxt_state = last_move ? IDLE : VERT;
      default: nxt_state = IDLE;
    endcase
  end

  // Output mux: UART passthrough when idle, tour commands otherwise
  always_comb begin
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_MID;
    err              = 1'b0;
    case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
      end
      VERT: begin
        cmd_rdy = move_ok;
        err     = !move_ok;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      WAIT_H: begin
        cmd  = horz_cmd;
        resp = last_move ? RESP_DONE : RESP_MID;
      end
      default: begin end
    endcase
  end

  assign tour_active = (state != IDLE);

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Randomized bench for tour_cmd_sequencer with a knight-move reference model.
module tb_tour_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        tour_active;
  logic        err;

  int checks = 0;
  int errors = 0;
  int a5_seen = 0;

  logic [7:0] mv_store [32];
  int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #5 clk = ~clk;

  // Move store: combinational read at the DUT's index
  assign move = mv_store[mv_indx];

  tour_cmd_sequencer dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .tour_active(tour_active), .err(err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bit_of(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m == (8'h01 << i)) return i;
    return 0;
  endfunction

  function automatic logic [15:0] exp_vert(input logic [7:0] m);
    int dy = dy_tab[bit_of(m)];
    int mag = (dy < 0) ? -dy : dy;
    return {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'(mag)};
  endfunction

  function automatic logic [15:0] exp_horz(input logic [7:0] m);
    int dx = dx_tab[bit_of(m)];
    int mag = (dx < 0) ? -dx : dx;
    return {4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'(mag)};
  endfunction

  // cmd_proc model: wait for a command, ack it, optionally complete it after a random delay
  task automatic do_cmd(input logic [15:0] exp_cmd, input logic [7:0] exp_resp, input bit do_resp);
    int n = 0;
    while (!cmd_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("cmd_rdy_wait", cmd_rdy, 1);
    check_val("cmd", cmd, exp_cmd);
    clr_cmd_rdy = 1'b1;
    send_resp   = 1'($urandom_range(0, 1));
    #1 check_val("clr_uart_blocked", clr_cmd_rdy_UART, 0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    check_val("cmd_rdy_drop", cmd_rdy, 0);
    repeat ($urandom_range(0, 3)) begin
      clr_cmd_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      check_val("cmd_rdy_wait_state", cmd_rdy, 0);
    end
    if (do_resp) begin
      check_val("resp", resp, exp_resp);
      if (resp == 8'hA5) a5_seen++;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
    end
  endtask

  task automatic run_moves(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      check_val("mv_indx", mv_indx, i);
      do_cmd(exp_vert(mv_store[i]), 8'h5A, 1);
      do_cmd(exp_horz(mv_store[i]), (i == 23) ? 8'hA5 : 8'h5A, 1);
    end
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mv_store[i] = 8'h01 << $urandom_range(0, 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    fill_random();
    repeat (2) @(negedge clk);
    check_val("rst_tour_active", tour_active, 0);
    check_val("rst_mv_indx", mv_indx, 0);
    check_val("rst_err", err, 0);
    check_val("rst_cmd_rdy", cmd_rdy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Idle passthrough
    cmd_UART = 16'h43F1; cmd_rdy_UART = 1'b1;
    #1;
    check_val("idle_cmd", cmd, 16'h43F1);
    check_val("idle_cmd_rdy", cmd_rdy, 1);
    check_val("idle_resp", resp, 8'hA5);
    clr_cmd_rdy = 1'b1;
    #1 check_val("idle_clr_uart", clr_cmd_rdy_UART, 1);
    @(negedge clk);
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] c = 16'($urandom);
      cmd_UART = c; cmd_rdy_UART = 1'($urandom_range(0, 1));
      #1;
      check_val("idle_rand_cmd", cmd, c);
      check_val("idle_rand_rdy", cmd_rdy, cmd_rdy_UART);
      @(negedge clk);
    end
    cmd_rdy_UART = 1'b0;

    // Full tour with cycling move bits
    for (int i = 0; i < 32; i++) mv_store[i] = 8'h01 << (i % 8);
    a5_seen = 0;
    pulse_start();
    check_val("start_cmd_rdy", cmd_rdy, 1);
    check_val("start_active", tour_active, 1);
    run_moves(0, 23);
    check_val("tour_end_active", tour_active, 0);
    check_val("tour_end_mv_indx", mv_indx, 23);
    check_val("tour_a5_count", a5_seen, 1);

    // Full tour with random moves
    fill_random();
    a5_seen = 0;
    pulse_start();
    run_moves(0, 23);
    check_val("rand_end_active", tour_active, 0);
    check_val("rand_end_mv_indx", mv_indx, 23);
    check_val("rand_a5_count", a5_seen, 1);

    // Illegal move at index 0
    mv_store[0] = 8'h00;
    pulse_start();
    check_val("ill0_err", err, 1);
    check_val("ill0_cmd_rdy", cmd_rdy, 0);
    @(negedge clk);
    check_val("ill0_err_clear", err, 0);
    check_val("ill0_active", tour_active, 0);

    // Illegal (two bits) move at index 5
    fill_random();
    mv_store[5] = 8'h03;
    pulse_start();
    run_moves(0, 4);
    check_val("ill5_mv_indx", mv_indx, 5);
    check_val("ill5_err", err, 1);
    check_val("ill5_cmd_rdy", cmd_rdy, 0);
    @(negedge clk);
    check_val("ill5_err_clear", err, 0);
    check_val("ill5_active", tour_active, 0);

    // Contention with a pending UART command, and a start_tour mid-tour
    fill_random();
    pulse_start();
    run_moves(0, 2);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    pulse_start();
    run_moves(3, 23);
    #1;
    check_val("cont_active", tour_active, 0);
    check_val("cont_fwd_cmd", cmd, 16'h1234);
    check_val("cont_fwd_rdy", cmd_rdy, 1);
    clr_cmd_rdy = 1'b1;
    #1 check_val("cont_fwd_clr", clr_cmd_rdy_UART, 1);
    @(negedge clk);
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

    // Asynchronous reset in WAIT_H at index 10
    fill_random();
    pulse_start();
    run_moves(0, 9);
    check_val("ar_mv_indx", mv_indx, 10);
    do_cmd(exp_vert(mv_store[10]), 8'h5A, 1);
    do_cmd(exp_horz(mv_store[10]), 8'h5A, 0);
    check_val("ar_wait_h_resp", resp, 8'h5A);
    check_val("ar_active_before", tour_active, 1);
    #2 rst = 1'b1;
    #1;
    check_val("ar_mv_indx_zero", mv_indx, 0);
    check_val("ar_cmd_rdy", cmd_rdy, 0);
    check_val("ar_active", tour_active, 0);
    check_val("ar_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("ar_idle_resp", resp, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
